// File: rtl/cpu_mem.sv
// Memory-side responder for the cpu: owns data RAM and instruction ROM, fills both from a
// byte stream while holding the cpu in reset, then serves fetch and data accesses in RUN.
module cpu_mem #(
    parameter int IMSB = 15,
    parameter int PMSB = 7,
    parameter int AMSB = 7,
    parameter int DMSB = 7
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [7:0]      s_data,
    output logic            cpu_setn,
    output logic            done,
    input  logic [PMSB:0]   pc,
    output logic [IMSB:0]   inst,
    input  logic [AMSB:0]   addr,
    input  logic [DMSB:0]   wdata,
    input  logic            write,
    output logic [DMSB:0]   rdata
);

    localparam int RAM_DEPTH = 2 ** (AMSB + 1);
    localparam int ROM_DEPTH = 2 ** (PMSB + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_RAM = 3'd1,
        ST_ROM_HI   = 3'd2,
        ST_ROM_LO   = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AMSB:0] rcnt_q, rcnt_d;
    logic [PMSB:0] pcnt_q, pcnt_d;
    logic [7:0]    hi_q, hi_d;
    logic          s_ready_q, s_ready_d;
    logic          cpu_setn_q, cpu_setn_d;
    logic          done_q, done_d;

    logic          accept_s;
    logic          ram_we_s;
    logic [AMSB:0] ram_waddr_s;
    logic [DMSB:0] ram_wdata_s;
    logic          rom_we_s;

    logic [DMSB:0] ram_mem [0:RAM_DEPTH-1];
    logic [IMSB:0] rom_mem [0:ROM_DEPTH-1];

    assign accept_s = s_valid && s_ready_q;

    // Next-state, load counters and memory write-port selection.
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        pcnt_d      = pcnt_q;
        hi_d        = hi_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = addr;
        ram_wdata_s = wdata;
        rom_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_RAM;
                    rcnt_d  = {(AMSB+1){1'b0}};
                    pcnt_d  = {(PMSB+1){1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_RAM: begin
                if (accept_s) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = rcnt_q;
                    ram_wdata_s = s_data;
                    rcnt_d      = rcnt_q + {{AMSB{1'b0}}, 1'b1};
                    if (rcnt_q == {(AMSB+1){1'b1}}) begin
                        state_d = ST_ROM_HI;
                    end else begin
                        state_d = ST_LOAD_RAM;
                    end
                end else begin
                    state_d = ST_LOAD_RAM;
                end
            end
            ST_ROM_HI: begin
                if (accept_s) begin
                    hi_d    = s_data;
                    state_d = ST_ROM_LO;
                end else begin
                    state_d = ST_ROM_HI;
                end
            end
            ST_ROM_LO: begin
                if (accept_s) begin
                    rom_we_s = 1'b1;
                    pcnt_d   = pcnt_q + {{PMSB{1'b0}}, 1'b1};
                    if (pcnt_q == {(PMSB+1){1'b1}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ROM_HI;
                    end
                end else begin
                    state_d = ST_ROM_LO;
                end
            end
            ST_RUN: begin
                // A write in the same cycle as a restart still belongs to the running cpu.
                ram_we_s = write;
                if (start) begin
                    state_d = ST_LOAD_RAM;
                    rcnt_d  = {(AMSB+1){1'b0}};
                    pcnt_d  = {(PMSB+1){1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops decode the next state so they change on the same edge as the state.
    always_comb begin
        s_ready_d  = (state_d == ST_LOAD_RAM) || (state_d == ST_ROM_HI) || (state_d == ST_ROM_LO);
        cpu_setn_d = (state_d == ST_RUN);
        done_d     = (state_d == ST_RUN);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= {(AMSB+1){1'b0}};
            pcnt_q     <= {(PMSB+1){1'b0}};
            hi_q       <= 8'h00;
            s_ready_q  <= 1'b0;
            cpu_setn_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            pcnt_q     <= pcnt_d;
            hi_q       <= hi_d;
            s_ready_q  <= s_ready_d;
            cpu_setn_q <= cpu_setn_d;
            done_q     <= done_d;
        end
    end

    // RAM write port; arrays carry no reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_mem[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // ROM write port, big-endian word assembly from the stream.
    always_ff @(posedge clk) begin
        if (rom_we_s) begin
            rom_mem[pcnt_q] <= {hi_q, s_data};
        end
    end

    assign s_ready  = s_ready_q;
    assign cpu_setn = cpu_setn_q;
    assign done     = done_q;
    assign inst     = (state_q == ST_RUN) ? rom_mem[pc] : {(IMSB+1){1'b0}};
    assign rdata    = ram_mem[addr];

endmodule

// File: tb/tb_cpu_mem.sv
// Directed bench for cpu_mem in the small configuration (4 RAM bytes, 4 ROM words).
module tb_cpu_mem;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        cpu_setn;
    logic        done;
    logic [1:0]  pc = 2'd0;
    logic [15:0] inst;
    logic [1:0]  addr = 2'd0;
    logic [7:0]  wdata = 8'h00;
    logic        write = 1'b0;
    logic [7:0]  rdata;

    int n_vec = 0;
    int n_err = 0;

    cpu_mem #(.IMSB(15), .PMSB(1), .AMSB(1), .DMSB(7)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cpu_setn(cpu_setn), .done(done),
        .pc(pc), .inst(inst),
        .addr(addr), .wdata(wdata), .write(write), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams nbytes from base; gap=1 offers a byte only on odd cycles and pulses start
    // on the idle ones. Returns how many cycles s_ready was high.
    task automatic stream(input logic [7:0] base, input int nbytes, input bit gap,
                          output int rdy_cycles);
        int i = 0;
        int guard = 0;
        rdy_cycles = 0;
        while (i < nbytes && guard < 200) begin
            s_valid = gap ? guard[0] : 1'b1;
            start   = gap ? ~guard[0] : 1'b0;
            s_data  = base + 8'(i);
            #1;
            if (nbytes == 12) begin
                check("load_setn", {15'd0, cpu_setn}, 16'h0000);
                check("load_inst", inst, 16'h0000);
            end
            if (s_ready) rdy_cycles++;
            if (s_ready && s_valid) i++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (guard >= 200) check("stream_timeout", 16'(guard), 16'(nbytes));
    endtask

    task automatic verify_image(input logic [7:0] base);
        for (int k = 0; k < 4; k++) begin
            addr = 2'(k);
            pc   = 2'(k);
            #1;
            check("ram", {8'h00, rdata}, {8'h00, base + 8'(k)});
            check("rom", inst, {base + 8'(4 + 2*k), base + 8'(5 + 2*k)});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int rc;

    initial begin
        // Reset state
        #12;
        check("rst_ready", {15'd0, s_ready}, 16'h0000);
        check("rst_setn", {15'd0, cpu_setn}, 16'h0000);
        check("rst_done", {15'd0, done}, 16'h0000);
        check("rst_inst", inst, 16'h0000);
        rstn = 1'b1;
        tick();
        tick();
        check("idle_ready", {15'd0, s_ready}, 16'h0000);

        // Continuous load 00..0B
        pulse_start();
        check("ld_ready", {15'd0, s_ready}, 16'h0001);
        stream(8'h00, 12, 1'b0, rc);
        check("ld1_cycles", 16'(rc), 16'd12);
        check("ld1_done", {15'd0, done}, 16'h0001);
        check("ld1_setn", {15'd0, cpu_setn}, 16'h0001);
        check("ld1_ready", {15'd0, s_ready}, 16'h0000);
        verify_image(8'h00);

        // RUN fetch and read-before-write
        pc = 2'd2;
        addr = 2'd1; wdata = 8'h5A; write = 1'b1;
        #1;
        check("run_inst", inst, 16'h0809);
        check("rbw_old", {8'h00, rdata}, 16'h0001);
        tick();
        write = 1'b0;
        #1;
        check("rbw_new", {8'h00, rdata}, 16'h005A);

        // Restart from RUN with a same-cycle write that must still commit
        addr = 2'd0; wdata = 8'h77; write = 1'b1;
        pulse_start();
        write = 1'b0;
        #1;
        check("rs_setn", {15'd0, cpu_setn}, 16'h0000);
        check("rs_done", {15'd0, done}, 16'h0000);
        check("rs_ready", {15'd0, s_ready}, 16'h0001);
        check("rs_wr_commit", {8'h00, rdata}, 16'h0077);

        // Write during LOAD_RAM is ignored
        addr = 2'd2; wdata = 8'hEE; write = 1'b1;
        tick();
        write = 1'b0;
        #1;
        check("load_wr_ign", {8'h00, rdata}, 16'h0002);

        // Gapped reload 20..2B with start pulses during load
        stream(8'h20, 12, 1'b1, rc);
        check("ld2_cycles", 16'(rc), 16'd24);
        check("ld2_done", {15'd0, done}, 16'h0001);
        verify_image(8'h20);

        // Reset mid-load after 6 bytes
        pulse_start();
        stream(8'hA0, 6, 1'b0, rc);
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", {15'd0, s_ready}, 16'h0000);
        check("mid_rst_setn", {15'd0, cpu_setn}, 16'h0000);
        check("mid_rst_done", {15'd0, done}, 16'h0000);
        check("mid_rst_inst", inst, 16'h0000);
        tick();
        rstn = 1'b1;
        tick();
        pulse_start();
        stream(8'h10, 12, 1'b0, rc);
        check("ld3_cycles", 16'(rc), 16'd12);
        check("ld3_done", {15'd0, done}, 16'h0001);
        verify_image(8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
